// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: EX-side instruction/control inputs, MEM-side registered
// outputs and the fetch redirect. The slave modport is the stage itself.
interface ex_mem_stage_if #(
  parameter int XLEN = 64,
  parameter int PCW  = 9
);
  logic            ex_valid;
  logic            ex_ready;
  logic [3:0]      inst_type_ex;
  logic [2:0]      br_op_ex;
  logic            beq, bne, slt, sltu, grt, grtu;
  logic [XLEN-1:0] out_reg;
  logic [XLEN-1:0] out_pc;
  logic [PCW-1:0]  br_target_ex;
  logic [XLEN-1:0] store_data_ex;
  logic [4:0]      rd_ex;
  logic            reg_we_ex, mem_rd_ex, mem_wr_ex;
  logic            stall_mem;
  logic            flush;
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_out;
  logic [XLEN-1:0] mem_store_data;
  logic [4:0]      mem_rd;
  logic            mem_reg_we, mem_rd_en, mem_wr_en;
  logic            redirect_valid;
  logic [PCW-1:0]  redirect_pc;

  modport master (
    output ex_valid, inst_type_ex, br_op_ex, beq, bne, slt, sltu, grt, grtu,
           out_reg, out_pc, br_target_ex, store_data_ex, rd_ex,
           reg_we_ex, mem_rd_ex, mem_wr_ex, stall_mem, flush,
    input  ex_ready, mem_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_we, mem_rd_en, mem_wr_en, redirect_valid, redirect_pc
  );

  modport slave (
    input  ex_valid, inst_type_ex, br_op_ex, beq, bne, slt, sltu, grt, grtu,
           out_reg, out_pc, br_target_ex, store_data_ex, rd_ex,
           reg_we_ex, mem_rd_ex, mem_wr_ex, stall_mem, flush,
    output ex_ready, mem_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_we, mem_rd_en, mem_wr_en, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch/jump resolution.
// Taken control transfers raise a one-cycle fetch redirect and the next SHADOW
// accepted instructions (wrong path) are dropped. stall_mem backpressures EX.
// Optional feature macro: BR_STATS_EN adds saturating taken/squash counters.
module ex_mem_stage #(
  parameter int XLEN   = 64,
  parameter int PCW    = 9,
  parameter int SHADOW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_mem_stage_if.slave bus
`ifdef BR_STATS_EN
  ,
  output logic [15:0]  br_taken_cnt,
  output logic [15:0]  br_squash_cnt
`endif
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [2:0] SHADOW_C = 3'(SHADOW);

  state_t         state;
  logic [2:0]     sq_cnt;
  logic           accept;
  logic           br_cond;
  logic           taken;
  logic [PCW-1:0] target;
  logic           unused_pc_hi;

  // JALR target only uses the low PCW bits of the ALU-computed address
  assign unused_pc_hi = ^bus.out_pc[XLEN-1:PCW];

  // stall only bites when MEM already holds something
  assign bus.ex_ready = !(bus.stall_mem && bus.mem_valid);
  assign accept       = bus.ex_valid && bus.ex_ready;

  // branch condition from ALU flags; undefined encodings never take
  always_comb begin
    br_cond = 1'b0;
    case (bus.br_op_ex)
      3'b000:  br_cond = bus.beq;
      3'b001:  br_cond = bus.bne;
      3'b100:  br_cond = bus.slt;
      3'b101:  br_cond = bus.grt | bus.beq;
      3'b110:  br_cond = bus.sltu;
      3'b111:  br_cond = bus.grtu | bus.beq;
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = ((bus.inst_type_ex == 4'b0101) && br_cond) ||
                  (bus.inst_type_ex == 4'b0110) || (bus.inst_type_ex == 4'b0111);
  assign target = (bus.inst_type_ex == 4'b0111) ? bus.out_pc[PCW-1:0] : bus.br_target_ex;

  // pipeline register + RUN/SQUASH squash FSM; flush beats stall beats accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= RUN;
      sq_cnt             <= '0;
      bus.mem_valid      <= 1'b0;
      bus.mem_alu_out    <= '0;
      bus.mem_store_data <= '0;
      bus.mem_rd         <= '0;
      bus.mem_reg_we     <= 1'b0;
      bus.mem_rd_en      <= 1'b0;
      bus.mem_wr_en      <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else if (bus.flush) begin
      state              <= RUN;
      sq_cnt             <= '0;
      bus.mem_valid      <= 1'b0;
      bus.mem_reg_we     <= 1'b0;
      bus.mem_rd_en      <= 1'b0;
      bus.mem_wr_en      <= 1'b0;
      bus.redirect_valid <= 1'b0;
    end else if (!bus.ex_ready) begin
      // hold MEM contents; a redirect never spans a stall cycle
      bus.redirect_valid <= 1'b0;
    end else begin
      bus.redirect_valid <= 1'b0;
      bus.mem_valid      <= 1'b0;
      bus.mem_reg_we     <= 1'b0;
      bus.mem_rd_en      <= 1'b0;
      bus.mem_wr_en      <= 1'b0;
      if (accept) begin
        if (state == RUN) begin
          bus.mem_valid      <= 1'b1;
          bus.mem_alu_out    <= bus.out_reg;
          bus.mem_store_data <= bus.store_data_ex;
          bus.mem_rd         <= bus.rd_ex;
          bus.mem_reg_we     <= bus.reg_we_ex;
          bus.mem_rd_en      <= bus.mem_rd_ex;
          bus.mem_wr_en      <= bus.mem_wr_ex;
          if (taken) begin
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= target;
            state              <= SQUASH;
            sq_cnt             <= SHADOW_C;
          end
        end else begin
          // wrong-path instruction: consumed but never reaches MEM
          sq_cnt <= sq_cnt - 3'd1;
          if (sq_cnt == 3'd1) state <= RUN;
        end
      end
    end
  end

`ifdef BR_STATS_EN
  logic take_evt, drop_evt;
  assign take_evt = accept && !bus.flush && (state == RUN) && taken;
  assign drop_evt = accept && !bus.flush && (state == SQUASH);

  // saturating statistics; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_cnt  <= '0;
      br_squash_cnt <= '0;
    end else begin
      if (take_evt && br_taken_cnt != 16'hFFFF)  br_taken_cnt  <= br_taken_cnt + 16'd1;
      if (drop_evt && br_squash_cnt != 16'hFFFF) br_squash_cnt <= br_squash_cnt + 16'd1;
    end
  end
`endif

endmodule
